// File: rtl/atomicity_mon_if.sv
// Bus between the CPU fetch stage and the atomicity monitor.
// ATOMICITY_DMA_EN adds the dma_en strobe.
interface atomicity_mon_if #(
    parameter int unsigned PC_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [PC_WIDTH-1:0]  pc;
    logic                 pc_en;
    logic                 irq;
`ifdef ATOMICITY_DMA_EN
    logic                 dma_en;
`endif
    logic                 reset;
    logic [2:0]           cause;
    logic [CNT_WIDTH-1:0] viol_cnt;

`ifdef ATOMICITY_DMA_EN
    modport master (output pc, pc_en, irq, dma_en, input reset, cause, viol_cnt);
    modport slave  (input pc, pc_en, irq, dma_en, output reset, cause, viol_cnt);
`else
    modport master (output pc, pc_en, irq, input reset, cause, viol_cnt);
    modport slave  (input pc, pc_en, irq, output reset, cause, viol_cnt);
`endif
endinterface

// File: rtl/atomicity_mon.sv
// Enforces single-entry/single-exit, uninterrupted execution of one protected
// code region and requests a system reset on violation. Option: ATOMICITY_DMA_EN.
module atomicity_mon #(
    parameter int unsigned         PC_WIDTH       = 16,
    parameter logic [PC_WIDTH-1:0] SMEM_BASE      = 16'hE000,
    parameter logic [PC_WIDTH-1:0] SMEM_SIZE      = 16'h1000,
    parameter logic [PC_WIDTH-1:0] RESET_HANDLER  = 16'hFFFE,
    parameter bit                  IRQ_OUTSIDE_OK = 1'b1,
    parameter int unsigned         CNT_WIDTH      = 8
) (
    input  logic            clk,
    input  logic            rst,
    atomicity_mon_if.slave  bus
);
    localparam logic [PC_WIDTH-1:0] LAST_ADDR = SMEM_BASE + SMEM_SIZE - PC_WIDTH'(2);

    localparam logic [2:0] ST_NOT_RC  = 3'd0;
    localparam logic [2:0] ST_FST_RC  = 3'd1;
    localparam logic [2:0] ST_MID_RC  = 3'd2;
    localparam logic [2:0] ST_LAST_RC = 3'd3;
    localparam logic [2:0] ST_KILL    = 3'd4;

    localparam logic [2:0] C_ENTRY = 3'd1;
    localparam logic [2:0] C_EXIT  = 3'd2;
    localparam logic [2:0] C_IRQ   = 3'd3;
    localparam logic [2:0] C_DMA   = 3'd4;
    localparam logic [2:0] C_BACK  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 reset_q, reset_d;
    logic [2:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       is_first, is_last, is_mid, in_region, irq_viol, dma_viol;
    logic [2:0] code;

    assign is_first  = (bus.pc == SMEM_BASE);
    assign is_last   = (bus.pc == LAST_ADDR);
    assign is_mid    = (bus.pc > SMEM_BASE) && (bus.pc < LAST_ADDR);
    assign in_region = (state_q == ST_FST_RC) || (state_q == ST_MID_RC) ||
                       (state_q == ST_LAST_RC);
    assign irq_viol  = bus.irq && (in_region || !IRQ_OUTSIDE_OK);
`ifdef ATOMICITY_DMA_EN
    assign dma_viol  = bus.dma_en && in_region;
`else
    assign dma_viol  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        code    = 3'd0;
        if (irq_viol) begin
            state_d = ST_KILL;
            code    = C_IRQ;
        end else if (dma_viol) begin
            state_d = ST_KILL;
            code    = C_DMA;
        end else if (bus.pc_en) begin
            case (state_q)
                ST_NOT_RC: begin
                    if (is_first) begin
                        state_d = ST_FST_RC;
                    end else if (is_mid || is_last) begin
                        state_d = ST_KILL;
                        code    = C_ENTRY;
                    end
                end
                ST_FST_RC: begin
                    if (is_mid) begin
                        state_d = ST_MID_RC;
                    end else if (!is_first) begin
                        state_d = ST_KILL;
                        code    = C_EXIT;
                    end
                end
                ST_MID_RC: begin
                    if (is_last) begin
                        state_d = ST_LAST_RC;
                    end else if (!is_mid) begin
                        state_d = ST_KILL;
                        code    = C_EXIT;
                    end
                end
                ST_LAST_RC: begin
                    if (is_first || is_mid) begin
                        state_d = ST_KILL;
                        code    = C_BACK;
                    end else if (!is_last) begin
                        state_d = ST_NOT_RC;
                    end
                end
                default: begin
                    if (bus.pc == RESET_HANDLER) state_d = ST_NOT_RC;
                    else                         state_d = ST_KILL;
                end
            endcase
        end
    end

    // Debug state only moves on a fresh entry into KILL, not while sitting in it.
    always_comb begin
        cause_d = cause_q;
        cnt_d   = cnt_q;
        if ((state_d == ST_KILL) && (state_q != ST_KILL)) begin
            cause_d = code;
            if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        reset_d = (state_d == ST_KILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_KILL;
            reset_q <= 1'b1;
            cause_q <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            reset_q <= reset_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.reset    = reset_q;
    assign bus.cause    = cause_q;
    assign bus.viol_cnt = cnt_q;
endmodule

// File: tb/tb_atomicity_mon.sv
// Scoreboard bench for atomicity_mon: two instances (irq tolerated / not
// tolerated outside the region) share stimulus and are checked against a table model.
module tb_atomicity_mon;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] pc_drv = 16'h0000;
    logic        en_drv = 1'b0;
    logic        irq_drv = 1'b0;
    logic        dma_drv = 1'b0;

    atomicity_mon_if #(.PC_WIDTH(16), .CNT_WIDTH(8)) if0 ();
    atomicity_mon_if #(.PC_WIDTH(16), .CNT_WIDTH(8)) if1 ();

    assign if0.pc = pc_drv;  assign if0.pc_en = en_drv;  assign if0.irq = irq_drv;
    assign if1.pc = pc_drv;  assign if1.pc_en = en_drv;  assign if1.irq = irq_drv;
`ifdef ATOMICITY_DMA_EN
    assign if0.dma_en = dma_drv;
    assign if1.dma_en = dma_drv;
`endif

    atomicity_mon #(.IRQ_OUTSIDE_OK(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    atomicity_mon #(.IRQ_OUTSIDE_OK(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Model: states 0 NOT,1 FST,2 MID,3 LAST,4 KILL; pc classes 0 OUT,1 FIRST,2 MID,3 LAST.
    int nxt_tab  [5][4];
    int code_tab [5][4];
    int m_state [2];
    int m_cause [2];
    int m_cnt   [2];
    bit irq_ok  [2] = '{1'b1, 1'b0};

    logic [23:0] sb_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic int classify(logic [15:0] p);
        if (p == 16'hE000) return 1;
        if (p == 16'hEFFE) return 3;
        if (p > 16'hE000 && p < 16'hEFFE) return 2;
        return 0;
    endfunction

    task automatic model(int k, bit r, logic [15:0] p, bit en, bit iq, bit dm);
        int nxt, code;
        bit inreg;
        if (r) begin
            m_state[k] = 4; m_cause[k] = 0; m_cnt[k] = 0;
            return;
        end
        inreg = (m_state[k] >= 1 && m_state[k] <= 3);
        nxt = m_state[k]; code = 0;
        if (iq && (inreg || !irq_ok[k])) begin
            nxt = 4; code = 3;
        end else if (dm && inreg) begin
            nxt = 4; code = 4;
        end else if (en) begin
            if (m_state[k] == 4) nxt = (p == 16'hFFFE) ? 0 : 4;
            else begin
                nxt  = nxt_tab[m_state[k]][classify(p)];
                code = code_tab[m_state[k]][classify(p)];
            end
        end
        if (nxt == 4 && m_state[k] != 4) begin
            m_cause[k] = code;
            m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
        end
        m_state[k] = nxt;
    endtask

    task automatic step(bit r, logic [15:0] p, bit en, bit iq, bit dm);
        logic [11:0] e0, e1;
        bit dmm;
        @(negedge clk);
        rst = r; pc_drv = p; en_drv = en; irq_drv = iq; dma_drv = dm;
`ifdef ATOMICITY_DMA_EN
        dmm = dm;
`else
        dmm = 1'b0;
`endif
        for (int k = 0; k < 2; k++) model(k, r, p, en, iq, dmm);
        e0 = {(m_state[0] == 4) ? 1'b1 : 1'b0, 3'(m_cause[0]), 8'(m_cnt[0])};
        e1 = {(m_state[1] == 4) ? 1'b1 : 1'b0, 3'(m_cause[1]), 8'(m_cnt[1])};
        sb_q.push_back({e0, e1});
    endtask

    task automatic go(logic [15:0] p);
        step(1'b0, p, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: the outputs are presented every cycle, so pop one entry per edge.
    initial begin
        logic [23:0] exp_v;
        logic [11:0] a0, a1;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                a0 = {if0.reset, if0.cause, if0.viol_cnt};
                a1 = {if1.reset, if1.cause, if1.viol_cnt};
                n_vec++;
                if (a0 !== exp_v[23:12]) begin
                    n_err++;
                    $display("FAIL dut0 rst/cause/cnt: got %b/%0d/%0d want %b/%0d/%0d",
                             a0[11], a0[10:8], a0[7:0], exp_v[23], exp_v[22:20], exp_v[19:12]);
                end
                n_vec++;
                if (a1 !== exp_v[11:0]) begin
                    n_err++;
                    $display("FAIL dut1 rst/cause/cnt: got %b/%0d/%0d want %b/%0d/%0d",
                             a1[11], a1[10:8], a1[7:0], exp_v[11], exp_v[10:8], exp_v[7:0]);
                end
            end
        end
    end

    initial begin
        logic [15:0] p;
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < 4; c++) begin nxt_tab[s][c] = 4; code_tab[s][c] = 0; end
        nxt_tab[0][0] = 0;  nxt_tab[0][1] = 1;  code_tab[0][2] = 1; code_tab[0][3] = 1;
        nxt_tab[1][1] = 1;  nxt_tab[1][2] = 2;  code_tab[1][0] = 2; code_tab[1][3] = 2;
        nxt_tab[2][2] = 2;  nxt_tab[2][3] = 3;  code_tab[2][0] = 2; code_tab[2][1] = 2;
        nxt_tab[3][3] = 3;  nxt_tab[3][0] = 0;  code_tab[3][1] = 5; code_tab[3][2] = 5;
        for (int k = 0; k < 2; k++) begin m_state[k] = 4; m_cause[k] = 0; m_cnt[k] = 0; end

        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        // legal run
        go(16'hFFFE); go(16'hE000); go(16'hE002); go(16'hEFFE); go(16'h4000);
        // illegal entry, recovery
        go(16'hE010); go(16'hFFFE); go(16'h1000);
        // early exit, then jump back from LAST
        go(16'hE000); go(16'hE002); go(16'h4000); go(16'hFFFE);
        go(16'hE000); go(16'hE002); go(16'hEFFE); go(16'hE004); go(16'hFFFE);
        // irq inside region, irq outside region
        go(16'hE000); go(16'hE100); step(1'b0, 16'hE102, 1'b1, 1'b1, 1'b0);
        go(16'hFFFE); step(1'b0, 16'h2000, 1'b1, 1'b1, 1'b0); go(16'hFFFE);
        // pc_en gating
        go(16'h3000);
        repeat (5) step(1'b0, 16'hE010, 1'b0, 1'b0, 1'b0);
        go(16'hE010); go(16'hFFFE);
        // DMA inside region (no effect unless the option is built in)
        go(16'hE000); step(1'b0, 16'hE000, 1'b1, 1'b0, 1'b1); go(16'hFFFE);
        // simultaneous rst and violation, then rst mid-region
        go(16'hE000);
        step(1'b1, 16'h4000, 1'b1, 1'b1, 1'b0);
        go(16'hFFFE); go(16'hE000); go(16'hE200);
        step(1'b1, 16'hE202, 1'b1, 1'b0, 1'b0);
        go(16'hE204); go(16'hFFFE);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: p = 16'hE000;
                1: p = 16'hEFFE;
                2: p = 16'hFFFE;
                3: p = 16'($urandom_range(16'hE001, 16'hEFFD));
                4: p = 16'($urandom_range(0, 16'hDFFF));
                default: p = (i % 2 == 0) ? 16'($urandom_range(16'hE002, 16'hEFFC))
                                          : 16'($urandom_range(16'hEFFF, 16'hFFFF));
            endcase
            step(($urandom_range(0, 199) == 0), p, ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0));
        end
        // counter saturation
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) begin go(16'hFFFE); go(16'hE010); end
        @(posedge clk); #2;
        n_vec++;
        if (if0.viol_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL saturation: got %0d want 255", if0.viol_cnt);
        end
        @(negedge clk); @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: got %0d left want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
